alu_issue_ctrl: RTL

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

---
 rtl/alu_pkg.sv | 60 ++++++
 rtl/alu_regfile.sv | 48 ++++
 rtl/alu_issue_ctrl.sv | 124 ++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : alu_pkg                                                    |
// | Description : Shared definitions for the ALU issue controller: opcode    |
// |               encodings, FSM state type, instruction field positions     |
// |               and field-extraction helpers.                              |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package alu_pkg;

   // ALU operation encodings driven on alu_ctrl
   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_XOR = 3'b100;
   localparam logic [2:0] ALU_SHL = 3'b101;
   localparam logic [2:0] ALU_SHR = 3'b110;
   localparam logic [2:0] ALU_CLR = 3'b111;

   // Controller states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   // Instruction word layout: op[15:13] rd[12:11] rs[10:9] use_imm[8] imm[7:0]
   localparam int OP_MSB      = 15;
   localparam int OP_LSB      = 13;
   localparam int RD_MSB      = 12;
   localparam int RD_LSB      = 11;
   localparam int RS_MSB      = 10;
   localparam int RS_LSB      = 9;
   localparam int USE_IMM_BIT = 8;
   localparam int IMM_MSB     = 7;
   localparam int IMM_LSB     = 0;

   function automatic logic [2:0] f_op(input logic [15:0] instr);
      return instr[OP_MSB:OP_LSB];
   endfunction

   function automatic logic [1:0] f_rd(input logic [15:0] instr);
      return instr[RD_MSB:RD_LSB];
   endfunction

   function automatic logic [1:0] f_rs(input logic [15:0] instr);
      return instr[RS_MSB:RS_LSB];
   endfunction

   function automatic logic f_use_imm(input logic [15:0] instr);
      return instr[USE_IMM_BIT];
   endfunction

   function automatic logic [7:0] f_imm(input logic [15:0] instr);
      return instr[IMM_MSB:IMM_LSB];
   endfunction

endpackage
`default_nettype wire

// File: rtl/alu_regfile.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : alu_regfile                                                |
// | Description : 4 x 8-bit register file, two asynchronous read ports and   |
// |               one synchronous write port, asynchronously reset to zero.  |
// | Ports       : clk, rst           - clock, async active-high reset        |
// |               rd_addr_a/rd_data_a - read port A                          |
// |               rd_addr_b/rd_data_b - read port B                          |
// |               wr_en/wr_addr/wr_data - write port (rising edge)           |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module alu_regfile (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] rd_addr_a,
   output logic [7:0] rd_data_a,
   input  logic [1:0] rd_addr_b,
   output logic [7:0] rd_data_b,
   input  logic       wr_en,
   input  logic [1:0] wr_addr,
   input  logic [7:0] wr_data
);

   logic [3:0][7:0] mem_q;
   logic [3:0][7:0] mem_d;

   // Reads return the pre-write contents, so a same-cycle write never
   // feeds back into the operands being used to compute it.
   assign rd_data_a = mem_q[rd_addr_a];
   assign rd_data_b = mem_q[rd_addr_b];

   always_comb begin
      mem_d = mem_q;
      if (wr_en) begin
         mem_d[wr_addr] = wr_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_q <= '0;
      end else begin
         mem_q <= mem_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : alu_issue_ctrl                                             |
// | Description : Accepts one 16-bit instruction at a time, presents its     |
// |               operands to an external combinational ALU, writes the      |
// |               result back to the register file and holds it on a         |
// |               valid/ready response port until consumed.                  |
// | Ports       : clk, rst             - clock, async active-high reset      |
// |               cmd_valid/ready/data - command handshake and instruction   |
// |               alu_a/alu_b/alu_ctrl - operands and op to external ALU     |
// |               alu_result           - ALU result (combinational)          |
// |               res_valid/ready      - response handshake                  |
// |               res_data/rd/zero     - captured result, dest reg, zero flag|
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module alu_issue_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [15:0] cmd_data,
   output logic [7:0]  alu_a,
   output logic [7:0]  alu_b,
   output logic [2:0]  alu_ctrl,
   input  logic [7:0]  alu_result,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [7:0]  res_data,
   output logic [1:0]  res_rd,
   output logic        res_zero
);

   import alu_pkg::*;

   state_t      state_q,     state_d;
   logic [15:0] instr_q,     instr_d;
   logic        res_valid_q, res_valid_d;
   logic [7:0]  res_data_q,  res_data_d;
   logic [1:0]  res_rd_q,    res_rd_d;
   logic        res_zero_q,  res_zero_d;
   logic        wr_en;
   logic [7:0]  reg_a;
   logic [7:0]  reg_b;

   alu_regfile u_regfile (
      .clk       (clk),
      .rst       (rst),
      .rd_addr_a (f_rd(instr_q)),
      .rd_data_a (reg_a),
      .rd_addr_b (f_rs(instr_q)),
      .rd_data_b (reg_b),
      .wr_en     (wr_en),
      .wr_addr   (f_rd(instr_q)),
      .wr_data   (alu_result)
   );

   // Operands are always derived from the latched instruction, so they
   // simply hold between commands rather than being gated to EXEC.
   assign alu_ctrl  = f_op(instr_q);
   assign alu_a     = reg_a;
   assign alu_b     = f_use_imm(instr_q) ? f_imm(instr_q) : reg_b;

   assign cmd_ready = (state_q == ST_IDLE);
   assign res_valid = res_valid_q;
   assign res_data  = res_data_q;
   assign res_rd    = res_rd_q;
   assign res_zero  = res_zero_q;

   always_comb begin
      state_d     = state_q;
      instr_d     = instr_q;
      res_valid_d = res_valid_q;
      res_data_d  = res_data_q;
      res_rd_d    = res_rd_q;
      res_zero_d  = res_zero_q;
      wr_en       = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               instr_d = cmd_data;
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            wr_en       = 1'b1;
            res_data_d  = alu_result;
            res_rd_d    = f_rd(instr_q);
            res_zero_d  = (alu_result == 8'h00);
            res_valid_d = 1'b1;
            state_d     = ST_RESP;
         end
         ST_RESP: begin
            if (res_ready) begin
               res_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end
         end
         default: begin
            res_valid_d = 1'b0;
            state_d     = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         instr_q     <= 16'h0000;
         res_valid_q <= 1'b0;
         res_data_q  <= 8'h00;
         res_rd_q    <= 2'd0;
         res_zero_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         instr_q     <= instr_d;
         res_valid_q <= res_valid_d;
         res_data_q  <= res_data_d;
         res_rd_q    <= res_rd_d;
         res_zero_q  <= res_zero_d;
      end
   end

endmodule
`default_nettype wire
